mux_seq: RTL and testbench
==========================

MUX_SEQ -- requirements
Module: mux_seq

Interface
REQ-001 Parameter WIDTH, default 1: bit width of each data channel.
REQ-002 Parameter CH, default 8: number of input channels, 2..256; it need not be a power of two.
REQ-003 Parameter SEL_W, default 3: select width; the block SHALL require SEL_W = ceil(log2(CH)).
REQ-004 Parameter DWELL_W, default 8: width of the scan dwell count.
REQ-005 Port clk, input, 1 bit: single clock; all state SHALL change on the rising edge.
REQ-006 Port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-007 Port in_data, input, CH*WIDTH bits: channel k occupies bits [k*WIDTH +: WIDTH].
REQ-008 Port sel_valid, input, 1 bit: select request is valid.
REQ-009 Port sel, input, SEL_W bits: requested channel index.
REQ-010 Port sel_ready, output, 1 bit: the block can accept a select request.
REQ-011 Port scan_en, input, 1 bit: auto-scan request.
REQ-012 Port dwell, input, DWELL_W bits: cycles per channel in scan, minus 1.
REQ-013 Port out_data, output, WIDTH bits: registered data of the selected channel.
REQ-014 Port out_valid, output, 1 bit: out_data holds data of a stable channel.
REQ-015 Port cur_sel, output, SEL_W bits: index of the currently selected channel.

Function
REQ-016 The state machine SHALL have the states IDLE, SWITCH, HOLD and SCAN.
REQ-017 A select request SHALL be accepted on an edge where sel_valid=1 and sel_ready=1.
REQ-018 sel_ready SHALL be 1 only in IDLE or HOLD, and only while scan_en is not in effect.
REQ-019 In IDLE or HOLD, an accepted select SHALL latch the target and move the state to SWITCH.
REQ-020 A sel value >= CH SHALL be clamped to a target of channel 0.
REQ-021 SWITCH SHALL last exactly one cycle.
REQ-022 At the end of SWITCH, cur_sel SHALL take the target, and the state SHALL go to SCAN if the scan request is pending, otherwise to HOLD.
REQ-023 On every edge, out_data SHALL be loaded with in_data channel cur_sel, and out_valid SHALL be loaded with 1 if the state is HOLD or SCAN, otherwise 0.
REQ-024 The latency from an accepted select to out_valid=1 with the new channel's data SHALL be 2 edges after the accept edge.
REQ-025 In SCAN, a dwell counter SHALL count from 0 up to dwell; on the edge where count >= dwell, cur_sel SHALL advance by 1 (CH-1 wraps to 0) and the counter SHALL clear.
REQ-026 out_valid SHALL stay 1 across scan advances.
REQ-027 Leaving SCAN (scan_en=0) SHALL go directly to HOLD on the current cur_sel with no SWITCH cycle.
REQ-028 If scan_en=1 and sel_valid=1 occur together in IDLE or HOLD, scan SHALL win: sel_ready=0, target=0, next state SWITCH, then SCAN.
REQ-029 A change in dwell during SCAN SHALL take effect on the next comparison.

Reset
REQ-030 While rst_n=0 at an edge, the block SHALL set state=IDLE, cur_sel=0, out_data=0, out_valid=0, the dwell counter to 0 and the target to 0.
REQ-031 sel_ready SHALL be 1 in the first cycle after reset.
REQ-032 Reset asserted during SWITCH or SCAN SHALL abort the operation immediately with no residual target.

Configuration
REQ-033 When MUX_SEQ_SCAN_EN is defined, the SCAN state, the dwell counter, and the scan_en/dwell behaviour SHALL be built in.
REQ-034 When MUX_SEQ_SCAN_EN is undefined, scan_en and dwell SHALL remain ports but be ignored, SCAN SHALL be unreachable, and channel changes SHALL occur only via the select handshake.

Verification
REQ-035 Scenario (CH=8, WIDTH=4, ch5=0xA): reset, then accept sel=5 at edge E0 -> E1: cur_sel=5, out_valid=0; E2: out_data=0xA, out_valid=1.
REQ-036 Scenario (CH=6): accept sel=7 -> cur_sel=0, and out_data equals channel 0 two edges after accept.
REQ-037 Scenario (macro on, dwell=2): scan_en=1 from HOLD -> cur_sel sequence 0,1,...,7,0 with each value held 3 cycles, and out_valid=1 throughout the scan.
REQ-038 Scenario: sel_valid=1 with sel=3 and scan_en=1 on the same edge in HOLD -> sel_ready=0, sel=3 not accepted, scan starts at channel 0.
REQ-039 Scenario: rst_n=0 for one edge mid-scan with cur_sel=4 -> next cycle cur_sel=0, out_valid=0, sel_ready=1, state IDLE.
REQ-040 Scenario (macro off): scan_en=1 with dwell=0 for 20 cycles in HOLD on channel 2 -> cur_sel stays 2 and sel_ready stays 1.

Source files
------------

// File: rtl/mux_seq.sv
// mux_seq: registered channel multiplexer with a select handshake and an
// optional auto-scan mode.
//
// Optional feature macro: MUX_SEQ_SCAN_EN builds in the SCAN state, the dwell
// counter and the scan_en/dwell behaviour. Without it, scan_en and dwell are
// ignored and the channel changes only through the select handshake.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   in_data    CH channels of WIDTH bits, channel k at [k*WIDTH +: WIDTH]
//   sel_valid  select request valid
//   sel        requested channel (values >= CH select channel 0)
//   sel_ready  select can be accepted (combinational: depends on scan_en)
//   scan_en    auto-scan request
//   dwell      cycles per channel in scan, minus 1
//   out_data   registered data of channel cur_sel
//   out_valid  out_data comes from a stable channel
//   cur_sel    currently selected channel
module mux_seq #(
   parameter int unsigned WIDTH   = 1,
   parameter int unsigned CH      = 8,
   parameter int unsigned SEL_W   = 3,
   parameter int unsigned DWELL_W = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [CH*WIDTH-1:0]   in_data,
   input  logic                  sel_valid,
   input  logic [SEL_W-1:0]      sel,
   output logic                  sel_ready,
   input  logic                  scan_en,
   input  logic [DWELL_W-1:0]    dwell,
   output logic [WIDTH-1:0]      out_data,
   output logic                  out_valid,
   output logic [SEL_W-1:0]      cur_sel
);

   localparam logic [1:0] st_idle   = 2'd0;
   localparam logic [1:0] st_switch = 2'd1;
   localparam logic [1:0] st_hold   = 2'd2;
   localparam logic [1:0] st_scan   = 2'd3;

   // Parameter sanity: the select must be exactly wide enough for CH.
   if (CH < 2 || CH > 256) begin : g_bad_ch
      $error("mux_seq: CH must be in 2..256");
   end
   if (SEL_W != $clog2(CH)) begin : g_bad_sel_w
      $error("mux_seq: SEL_W must equal ceil(log2(CH))");
   end

   logic [1:0]         state, nxt_state;
   logic [SEL_W-1:0]   target, nxt_target;
   logic [SEL_W-1:0]   nxt_cur_sel;
   logic [SEL_W-1:0]   sel_clamped;
   logic               scan_req;
   logic [WIDTH-1:0]   chan [CH];

   // Unpack the flat input bus into per-channel words.
   for (genvar k = 0; k < CH; k++) begin : g_chan
      assign chan[k] = in_data[k*WIDTH +: WIDTH];
   end

`ifdef MUX_SEQ_SCAN_EN
   logic [DWELL_W-1:0] cnt, nxt_cnt;
   assign scan_req = scan_en;
`else
   logic unused_scan;
   assign scan_req    = 1'b0;
   assign unused_scan = ^{scan_en, dwell};
`endif

   // Out-of-range requests fall back to channel 0.
   assign sel_clamped = (32'(sel) >= CH) ? '0 : sel;

   // A pending scan request blocks the select handshake.
   assign sel_ready = ((state == st_idle) || (state == st_hold)) && !scan_req;

   // Next-state logic.
   always_comb begin
      nxt_state   = state;
      nxt_target  = target;
      nxt_cur_sel = cur_sel;
`ifdef MUX_SEQ_SCAN_EN
      nxt_cnt     = cnt;
`endif
      case (state)
         st_idle, st_hold: begin
            if (scan_req) begin
               nxt_target = '0;
               nxt_state  = st_switch;
            end else if (sel_valid) begin
               nxt_target = sel_clamped;
               nxt_state  = st_switch;
            end
         end
         st_switch: begin
            nxt_cur_sel = target;
            nxt_state   = scan_req ? st_scan : st_hold;
`ifdef MUX_SEQ_SCAN_EN
            nxt_cnt     = '0;
`endif
         end
         st_scan: begin
`ifdef MUX_SEQ_SCAN_EN
            if (!scan_req) begin
               nxt_state = st_hold;
               nxt_cnt   = '0;
            end else if (cnt >= dwell) begin
               nxt_cur_sel = (32'(cur_sel) == CH - 1) ? '0 : cur_sel + SEL_W'(1);
               nxt_cnt     = '0;
            end else begin
               nxt_cnt = cnt + DWELL_W'(1);
            end
`else
            nxt_state = st_idle;
`endif
         end
         default: nxt_state = st_idle;
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= st_idle;
         target    <= '0;
         cur_sel   <= '0;
         out_data  <= '0;
         out_valid <= 1'b0;
`ifdef MUX_SEQ_SCAN_EN
         cnt       <= '0;
`endif
      end else begin
         state     <= nxt_state;
         target    <= nxt_target;
         cur_sel   <= nxt_cur_sel;
         out_data  <= chan[cur_sel];
         out_valid <= (state == st_hold) || (state == st_scan);
`ifdef MUX_SEQ_SCAN_EN
         cnt       <= nxt_cnt;
`endif
      end
   end

endmodule

// File: tb/tb_mux_seq.sv
// tb_mux_seq: directed scenarios plus randomized traffic for mux_seq (CH=6,
// WIDTH=4), checked against a cycle-level behavioural model.
module tb_mux_seq;

   localparam int unsigned WIDTH   = 4;
   localparam int unsigned CH      = 6;
   localparam int unsigned SEL_W   = 3;
   localparam int unsigned DWELL_W = 4;

   // model modes
   localparam int M_IDLE = 0, M_SW = 1, M_HOLD = 2, M_SCAN = 3;

   logic                 clk = 1'b0;
   logic                 rst_n;
   logic [CH*WIDTH-1:0]  in_data;
   logic                 sel_valid;
   logic [SEL_W-1:0]     sel;
   logic                 sel_ready;
   logic                 scan_en;
   logic [DWELL_W-1:0]   dwell;
   logic [WIDTH-1:0]     out_data;
   logic                 out_valid;
   logic [SEL_W-1:0]     cur_sel;

   int tests = 0;
   int fails = 0;

   int m_mode, m_cur, m_tgt, m_cnt, m_od, m_ov;

   mux_seq #(.WIDTH(WIDTH), .CH(CH), .SEL_W(SEL_W), .DWELL_W(DWELL_W)) dut (
      .clk(clk), .rst_n(rst_n), .in_data(in_data), .sel_valid(sel_valid),
      .sel(sel), .sel_ready(sel_ready), .scan_en(scan_en), .dwell(dwell),
      .out_data(out_data), .out_valid(out_valid), .cur_sel(cur_sel));

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int chan_val(input int k);
      return int'(in_data[k*WIDTH +: WIDTH]);
   endfunction

   function automatic bit scan_on();
`ifdef MUX_SEQ_SCAN_EN
      return scan_en;
`else
      return 1'b0;
`endif
   endfunction

   // One clock: check the handshake before the edge, advance the model with
   // the inputs as seen at the edge, then check the registered outputs.
   task automatic step();
      int n_mode, n_cur, n_tgt, n_cnt;
      bit rdy;
      #1;
      rdy = ((m_mode == M_IDLE) || (m_mode == M_HOLD)) && !scan_on();
      chk("sel_ready", 32'(sel_ready), 32'(rdy));
      n_mode = m_mode; n_cur = m_cur; n_tgt = m_tgt; n_cnt = m_cnt;
      if (!rst_n) begin
         n_mode = M_IDLE; n_cur = 0; n_tgt = 0; n_cnt = 0;
         m_od = 0; m_ov = 0;
      end else begin
         m_od = chan_val(m_cur);
         m_ov = (m_mode == M_HOLD || m_mode == M_SCAN) ? 1 : 0;
         if (m_mode == M_IDLE || m_mode == M_HOLD) begin
            if (scan_on()) begin
               n_tgt = 0; n_mode = M_SW;
            end else if (sel_valid) begin
               n_tgt = (int'(sel) < CH) ? int'(sel) : 0; n_mode = M_SW;
            end
         end else if (m_mode == M_SW) begin
            n_cur = m_tgt; n_cnt = 0;
            n_mode = scan_on() ? M_SCAN : M_HOLD;
         end else begin
            if (!scan_on()) begin
               n_mode = M_HOLD; n_cnt = 0;
            end else if (m_cnt >= int'(dwell)) begin
               n_cur = (m_cur + 1) % CH; n_cnt = 0;
            end else begin
               n_cnt = m_cnt + 1;
            end
         end
      end
      @(posedge clk);
      m_mode = n_mode; m_cur = n_cur; m_tgt = n_tgt; m_cnt = n_cnt;
      #1;
      chk("cur_sel", 32'(cur_sel), 32'(m_cur));
      chk("out_valid", 32'(out_valid), 32'(m_ov));
      chk("out_data", 32'(out_data), 32'(m_od));
   endtask

   initial begin
      logic [31:0] cdata;
      bit found;
      m_mode = M_IDLE; m_cur = 0; m_tgt = 0; m_cnt = 0; m_od = 0; m_ov = 0;
      // ch5..ch0 = A,9,5,C,7,3
      cdata = 32'h00A95C73;
      in_data = cdata[CH*WIDTH-1:0];
      rst_n = 1'b0; sel_valid = 1'b0; sel = '0; scan_en = 1'b0; dwell = '0;
      @(negedge clk);
      step(); step();
      rst_n = 1'b1;
      #1;
      chk("rst_cur_sel", 32'(cur_sel), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_data", 32'(out_data), 32'd0);
      chk("rst_sel_ready", 32'(sel_ready), 32'd1);

      // Accept sel=5: cur_sel one edge later, valid data two edges later.
      sel_valid = 1'b1; sel = 3'd5;
      step();
      sel_valid = 1'b0;
      step();
      chk("e1_cur_sel", 32'(cur_sel), 32'd5);
      chk("e1_out_valid", 32'(out_valid), 32'd0);
      step();
      chk("e2_out_data", 32'(out_data), 32'hA);
      chk("e2_out_valid", 32'(out_valid), 32'd1);

      // Out-of-range select clamps to channel 0.
      sel_valid = 1'b1; sel = 3'd7;
      step();
      sel_valid = 1'b0;
      step();
      chk("clamp_cur_sel", 32'(cur_sel), 32'd0);
      step();
      chk("clamp_out_data", 32'(out_data), 32'h3);

      // Park on channel 2.
      sel_valid = 1'b1; sel = 3'd2;
      step();
      sel_valid = 1'b0;
      step(); step();
      chk("hold2_cur_sel", 32'(cur_sel), 32'd2);

`ifdef MUX_SEQ_SCAN_EN
      // Scan beats a simultaneous select; scan starts at channel 0.
      sel_valid = 1'b1; sel = 3'd3; scan_en = 1'b1; dwell = 4'd2;
      #1;
      chk("scan_wins_ready", 32'(sel_ready), 32'd0);
      step();
      sel_valid = 1'b0;
      step();
      chk("scan_start_cur", 32'(cur_sel), 32'd0);
      for (int i = 1; i < 3 * (CH + 1); i++) begin
         step();
         chk("scan_seq_cur", 32'(cur_sel), 32'((i / 3) % CH));
         chk("scan_seq_valid", 32'(out_valid), 32'd1);
      end
      // Reset in the middle of a scan with cur_sel=4.
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         if (cur_sel == 3'd4) found = 1'b1;
         else step();
      end
      chk("scan_reach_4", 32'(found), 32'd1);
      rst_n = 1'b0; scan_en = 1'b0;
      step();
      rst_n = 1'b1;
      #1;
      chk("midscan_rst_cur", 32'(cur_sel), 32'd0);
      chk("midscan_rst_valid", 32'(out_valid), 32'd0);
      chk("midscan_rst_ready", 32'(sel_ready), 32'd1);
`else
      // Scan request is ignored: selection and handshake unchanged.
      scan_en = 1'b1; dwell = '0;
      for (int i = 0; i < 20; i++) begin
         step();
         chk("noscan_cur", 32'(cur_sel), 32'd2);
         chk("noscan_ready", 32'(sel_ready), 32'd1);
      end
      scan_en = 1'b0;
`endif

      // Randomized traffic.
      for (int i = 0; i < 1500; i++) begin
         rst_n     = ($urandom_range(0, 149) != 0);
         sel_valid = $urandom_range(0, 2) != 0;
         sel       = SEL_W'($urandom_range(0, 7));
         if ($urandom_range(0, 24) == 0) scan_en = ~scan_en;
         if ($urandom_range(0, 19) == 0) dwell = DWELL_W'($urandom_range(0, 3));
         in_data   = (CH*WIDTH)'($urandom);
         step();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
